// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem read port and the F/D register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble performance counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic            D_valid,
    output logic [ILEN-1:0] D_instr,
    output logic [XLEN-1:0] D_pc,
    output logic [XLEN-1:0] D_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            d_valid_q;
    logic [ILEN-1:0] d_instr_q;
    logic [XLEN-1:0] d_pc_q;
    logic [XLEN-1:0] d_pc4_q;

    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_plus4             = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            d_valid_q <= 1'b0;
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= '0;
            d_pc4_q   <= '0;
        end else begin
            case (state_q)
                StBoot: begin
                    // F/D is already a bubble here, so only a redirect matters
                    state_q <= StRun;
                    if (flush_D) begin
                        pc_q <= redirect_aligned;
                    end
                end
                StRun: begin
                    if (flush_D) begin
                        pc_q      <= redirect_aligned;
                        d_valid_q <= 1'b0;
                        d_instr_q <= NOP_INSTR;
                    end else if (stall_D) begin
                        // Hold everything; the same address is re-presented next cycle
                        pc_q <= pc_q;
                    end else if (imem_valid) begin
                        d_instr_q <= imem_rdata;
                        d_pc_q    <= pc_q;
                        d_pc4_q   <= pc_plus4;
                        d_valid_q <= 1'b1;
                        pc_q      <= pc_plus4;
                    end else begin
                        d_valid_q <= 1'b0;
                        d_instr_q <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

    assign imem_req  = (state_q == StRun);
    assign imem_addr = pc_q;
    assign D_valid   = d_valid_q;
    assign D_instr   = d_instr_q;
    assign D_pc      = d_pc_q;
    assign D_pc4     = d_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic        stall_evt;
    logic        bubble_evt;
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    assign stall_evt  = (state_q == StRun) && stall_D && !flush_D;
    assign bubble_evt = (state_q == StRun) && (flush_D || (!stall_D && !imem_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bubble_evt && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; imem returns addr ^ 32'hDEAD_0000 with no waits
// unless imem_valid is dropped by the vector.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_D = 1'b0;
    logic        flush_D = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid = 1'b0;
    logic        D_valid;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .D_valid     (D_valid),
        .D_instr     (D_instr),
        .D_pc        (D_pc),
        .D_pc4       (D_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    typedef struct {
        logic        st;
        logic        fl;
        logic [31:0] rp;
        logic        iv;
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] dpc;
        logic [31:0] dpc4;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic st, input logic fl, input logic [31:0] rp, input logic iv,
                       input logic req, input logic [31:0] addr, input logic dv,
                       input logic [31:0] dpc, input logic [31:0] dpc4);
        vec_t v;
        v.st = st; v.fl = fl; v.rp = rp; v.iv = iv;
        v.req = req; v.addr = addr; v.dv = dv; v.dpc = dpc; v.dpc4 = dpc4;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected D_instr follows from D_valid/D_pc: a real word or the bubble NOP.
    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic dv, input logic [31:0] dpc, input logic [31:0] dpc4);
        chk({tag, " imem_req"},  32'(imem_req), 32'(req));
        chk({tag, " imem_addr"}, imem_addr, addr);
        chk({tag, " D_valid"},   32'(D_valid), 32'(dv));
        chk({tag, " D_instr"},   D_instr, dv ? mem_word(dpc) : NOP);
        chk({tag, " D_pc"},      D_pc, dpc);
        chk({tag, " D_pc4"},     D_pc4, dpc4);
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] rp, input logic iv);
        stall_D = st; flush_D = fl; redirect_pc = rp; imem_valid = iv;
    endtask

    initial begin
        //  st    fl    redirect        iv    req   addr            dv    D_pc            D_pc4
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,          1'b0, 32'h0,          32'h0);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4,          1'b1, 32'h0,          32'h4);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8,          1'b1, 32'h4,          32'h8);
        add(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC,          1'b1, 32'h8,          32'hC);
        add(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC,          1'b1, 32'h8,          32'hC);
        add(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC,          1'b1, 32'h8,          32'hC);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC,          1'b1, 32'h8,          32'hC);
        add(1'b1, 1'b1, 32'h103,        1'b1, 1'b1, 32'h10,         1'b1, 32'hC,          32'h10);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h100,        1'b0, 32'hC,          32'h10);
        add(1'b0, 1'b1, 32'h20,         1'b1, 1'b1, 32'h104,        1'b1, 32'h100,        32'h104);
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h20,         1'b0, 32'h100,        32'h104);
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 32'h20,         1'b0, 32'h100,        32'h104);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h20,         1'b0, 32'h100,        32'h104);
        add(1'b0, 1'b1, 32'hFFFF_FFFE,  1'b1, 1'b1, 32'h24,         1'b1, 32'h20,         32'h24);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFC,  1'b0, 32'h20,         32'h24);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,          1'b1, 32'hFFFF_FFFC,  32'h0);
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4,          1'b1, 32'h0,          32'h4);

        // Asynchronous reset: outputs must clear before any clock edge
        #2 rst_n = 1'b0;
        #1 chk_outs("async reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < tv.size(); k++) begin
            chk_outs($sformatf("vec%0d", k), tv[k].req, tv[k].addr, tv[k].dv, tv[k].dpc,
                     tv[k].dpc4);
            drive(tv[k].st, tv[k].fl, tv[k].rp, tv[k].iv);
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt after table", perf_stall_cnt, 32'd3);
        chk("perf_bubble_cnt after table", perf_bubble_cnt, 32'd5);
`endif

        // Reset pulsed mid-cycle, then fetch restarts at RESET_PC after one BOOT cycle
        #2 rst_n = 1'b0;
        #1 chk_outs("mid reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt reset", perf_stall_cnt, 32'd0);
        chk("perf_bubble_cnt reset", perf_bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk_outs("restart boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_outs("restart run0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_outs("restart run1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4);

        // Flush and stall during BOOT: redirect taken, stall ignored, nothing counted
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h43, 1'b1);
        chk_outs("boot flush boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_outs("boot flush run0", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk_outs("boot flush run1", 1'b1, 32'h44, 1'b1, 32'h40, 32'h44);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cnt boot", perf_stall_cnt, 32'd0);
        chk("perf_bubble_cnt boot", perf_bubble_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It owns the program counter and drives the instruction-memory read port. It also owns the F/D pipeline register that feeds decode. It obeys the hazard unit's `stall_D` (load-use) and the execute stage's branch/jump redirect (`flush_D` + `redirect_pc`), inserting bubbles where required.

## Interface
Parameters:
- `XLEN`, 32: PC and address width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: instruction word presented on `D_instr` for a bubble.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall_D`  in  1: hold F/D register and PC (from hazard unit).
- `flush_D`  in  1: branch/jump taken in EX; squash F/D, load PC from `redirect_pc`.
- `redirect_pc`  in  XLEN: redirect target, valid when `flush_D`=1.
- `imem_req`  out  1: fetch request for `imem_addr` this cycle.
- `imem_addr`  out  XLEN: fetch address; always equals the PC register.
- `imem_rdata`  in  ILEN: instruction for `imem_addr`, same cycle.
- `imem_valid`  in  1: `imem_rdata` valid this cycle (0 = wait state).
- `D_valid`  out  1: F/D register holds a real instruction.
- `D_instr`  out  ILEN: registered instruction.
- `D_pc`  out  XLEN: PC of `D_instr`.
- `D_pc4`  out  XLEN: `D_pc`+4, used for link address.

## Operation
- FSM with two states, BOOT and RUN. Reset enters BOOT.
- BOOT lasts exactly one cycle. In BOOT, `imem_req`=0 and the PC holds `RESET_PC`. BOOT then moves to RUN unconditionally.
- In RUN, `imem_req`=1 every cycle.
- Per-cycle update in RUN, in priority order (first match wins):
  1. `flush_D`=1: PC <= {`redirect_pc`[XLEN-1:2], 2'b00}. `D_valid`<=0 and `D_instr`<=`NOP_INSTR`. This applies even if `stall_D`=1 or `imem_valid`=1 in the same cycle; the fetched word is discarded.
  2. `stall_D`=1: PC and all F/D outputs hold. The same address is re-presented next cycle, so no skid storage is needed.
  3. `imem_valid`=1: `D_instr`<=`imem_rdata`, `D_pc`<=PC, `D_pc4`<=PC+4, `D_valid`<=1, PC<=PC+4.
  4. Otherwise (wait state): PC holds. `D_valid`<=0 and `D_instr`<=`NOP_INSTR`; `D_pc`/`D_pc4` hold.
- `flush_D` or `stall_D` arriving during BOOT: `flush_D` still loads the PC (rule 1) and the state still advances. `stall_D` is ignored because F/D is already a bubble.
- Arithmetic: PC+4 is computed modulo 2^XLEN. PC `{XLEN{1}}-3` advances to 0, with no error.
- The PC low two bits are always 0.

## Timing
- Reset values: state=BOOT, PC=`RESET_PC`, `imem_req`=0, `D_valid`=0, `D_instr`=`NOP_INSTR`, `D_pc`=0, `D_pc4`=0. The reset clears these asynchronously on `rst_n` fall.
- Fetch latency: a word accepted in cycle N (`imem_valid`=1, no stall/flush) appears on the `D_*` outputs in cycle N+1.
- Redirect: `flush_D` in cycle N gives `imem_addr`=`redirect_pc` in N+1. The earliest valid target instruction is on `D_*` in N+2, so a taken branch costs one bubble in D in addition to the squashed word.
- Stall: `stall_D` high for k cycles freezes `D_*` and `imem_addr` for exactly those k cycles. On release, the pipeline advances in the following cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. The first request after `rst_n` rises is issued one cycle later (the BOOT cycle).
- `imem_addr` is a registered output; `imem_req` is decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds `perf_stall_cnt` and `perf_bubble_cnt` outputs, both 32 bits, reset to 0.
  - `perf_stall_cnt` increments in every RUN cycle with `stall_D`=1 and `flush_D`=0.
  - `perf_bubble_cnt` increments in every RUN cycle where rule 1 or rule 4 loads a bubble.
  - Both counters saturate at 32'hFFFF_FFFF.
- `FETCH_PERF_CNT_EN` undefined: the counters and ports are absent. Fetch behaviour is identical in both builds.

## Test plan
- Reset release, `imem_valid`=1 throughout, `RESET_PC`=0 -> BOOT cycle with `imem_req`=0. Then `imem_addr` steps 0, 4, 8, and `D_pc`=0 with `D_valid`=1 appears two cycles after `rst_n` rises.
- `stall_D` high for 3 cycles while `D_pc`=8 -> `D_pc`/`D_instr` and `imem_addr`=12 are frozen for 3 cycles. Then `D_pc`=12 appears the cycle after release.
- `flush_D`=1 with `redirect_pc`=32'h0000_0103 and `stall_D`=1 simultaneously -> the next cycle has `D_valid`=0, `D_instr`=32'h13 and `imem_addr`=32'h100. The following cycle has `D_pc`=32'h100.
- `imem_valid`=0 for 2 cycles at PC 32'h20 -> `D_valid`=0 for 2 cycles with the PC held. Then `D_pc`=32'h20 with `D_valid`=1.
- PC at 32'hFFFF_FFFC with `imem_valid`=1 -> the next `imem_addr`=0 and `D_pc4`=0.
- `rst_n` pulsed low mid-stream -> all outputs are at reset values within the same cycle, and fetch restarts at `RESET_PC`. With `FETCH_PERF_CNT_EN`, the counters read 0 after reset and match the counted stall/bubble cycles of the earlier scenarios.
